// File: rtl/alu_multicycle_pkg.sv
// Shared definitions for the multi-cycle ALU: operation encodings, FSM states
// and a small decode helper.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Operand/result handshake bundle between the execute stage and the ALU.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] In_A;
  logic [WIDTH-1:0] In_B;
  logic [3:0]       ALUControl;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Out_ALU;
  logic             Zero;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output In_A, In_B, ALUControl, in_valid, out_ready,
    input  in_ready, Out_ALU, Zero, out_valid
  );

  modport slave (
    input  In_A, In_B, ALUControl, in_valid, out_ready,
    output in_ready, Out_ALU, Zero, out_valid
  );
endinterface

// File: rtl/alu_iter_unit.sv
// Iterative datapath for shifts (one bit per step) and radix-2 shift-add multiply.
// Loaded on start, advanced on step; last flags the final step.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc,
  output logic             last
);

  // One extra counter bit so a multiply can count a full WIDTH steps.
  localparam int CW = SHW + 1;
  localparam logic [CW-1:0] CNT_MUL = CW'(WIDTH);

  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [CW-1:0]    cnt_r;
  logic [3:0]       op_r;

  // Operand load on start, one shift/add iteration per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r    <= {WIDTH{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      op_r     <= 4'b0000;
    end else if (start) begin
      op_r     <= op;
      mcand_r  <= a;
      mplier_r <= b;
      if (op == ALU_MUL) begin
        acc_r <= {WIDTH{1'b0}};
        cnt_r <= CNT_MUL;
      end else begin
        acc_r <= a;
        cnt_r <= {1'b0, b[SHW-1:0]};
      end
    end else if (step && (cnt_r != {CW{1'b0}})) begin
      cnt_r <= cnt_r - CW'(1);
      case (op_r)
        ALU_SLL: acc_r <= {acc_r[WIDTH-2:0], 1'b0};
        ALU_SRL: acc_r <= {1'b0, acc_r[WIDTH-1:1]};
        ALU_SRA: acc_r <= {acc_r[WIDTH-1], acc_r[WIDTH-1:1]};
        ALU_MUL: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end else begin
            acc_r <= acc_r;
          end
          mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
        end
        default: acc_r <= acc_r;
      endcase
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc  = acc_r;
  assign last = (cnt_r == CW'(1));

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshakes. Single-cycle ops resolve from
// captured operands; shifts and multiply run in alu_iter_unit.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_multicycle_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_r;
  state_e           state_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] out_alu_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] result_s;
  logic [WIDTH-1:0] iter_acc_s;
  logic             iter_last_s;
  logic             accept_s;
  logic             step_s;

  assign accept_s      = bus.in_valid && (state_r == IDLE);
  assign bus.in_ready  = (state_r == IDLE);
  assign bus.Out_ALU   = out_alu_r;
  assign bus.Zero      = (out_alu_r == {WIDTH{1'b0}});
  assign bus.out_valid = out_valid_r;

  alu_iter_unit #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept_s),
    .step  (step_s),
    .op    (bus.ALUControl),
    .a     (bus.In_A),
    .b     (bus.In_B),
    .acc   (iter_acc_s),
    .last  (iter_last_s)
  );

  // Next-state decode and iteration enable.
  always_comb begin
    state_s = state_r;
    step_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_s = IDLE;
        end else if (bus.ALUControl == ALU_MUL) begin
          state_s = MUL;
        end else if (is_shift(bus.ALUControl) && (bus.In_B[SHW-1:0] != {SHW{1'b0}})) begin
          state_s = SHIFT;
        end else begin
          state_s = DONE;
        end
      end
      SHIFT, MUL: begin
        step_s = 1'b1;
        if (iter_last_s) begin
          state_s = DONE;
        end else begin
          state_s = state_r;
        end
      end
      DONE: begin
        if (out_valid_r && bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Result select; shifts (including shamt 0) and multiply come from the iterator.
  always_comb begin
    result_s = {WIDTH{1'b0}};
    case (op_r)
      ALU_ADD: result_s = a_r + b_r;
      ALU_SUB: result_s = a_r - b_r;
      ALU_AND: result_s = a_r & b_r;
      ALU_XOR: result_s = a_r ^ b_r;
      ALU_OR:  result_s = a_r | b_r;
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL: result_s = iter_acc_s;
      default: result_s = {WIDTH{1'b0}};
    endcase
  end

  // State, operand capture and registered result/valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      op_r        <= 4'b0000;
      out_alu_r   <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        a_r  <= bus.In_A;
        b_r  <= bus.In_B;
        op_r <= bus.ALUControl;
      end else begin
        op_r <= op_r;
      end
      // Result is latched on the first DONE cycle, then held until consumed.
      if ((state_r == DONE) && !out_valid_r) begin
        out_alu_r   <= result_s;
        out_valid_r <= 1'b1;
      end else if ((state_r == DONE) && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle at WIDTH=32 and WIDTH=8.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_multicycle_if #(.WIDTH(32)) bus32 ();
  alu_multicycle_if #(.WIDTH(8))  bus8 ();

  alu_multicycle #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
  alu_multicycle #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] model32(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a & b;
      4'b0011: return a ^ b;
      4'b0100: return a << b[4:0];
      4'b0101: return a | b;
      4'b0110: return a >> b[4:0];
      4'b0111: return $unsigned($signed(a) >>> b[4:0]);
      4'b1000: return a * b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [7:0] model8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a & b;
      4'b0011: return a ^ b;
      4'b0100: return a << b[2:0];
      4'b0101: return a | b;
      4'b0110: return a >> b[2:0];
      4'b0111: return $unsigned($signed(a) >>> b[2:0]);
      4'b1000: return a * b;
      default: return 8'h0;
    endcase
  endfunction

  function automatic int lat_of(input logic [3:0] op, input int sh, input int w);
    if (op == 4'b1000) return w + 1;
    if ((op == 4'b0100 || op == 4'b0110 || op == 4'b0111) && sh != 0) return sh + 1;
    return 1;
  endfunction

  task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    exp_t e;
    int w = 0;
    @(negedge clk);
    while (bus32.in_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    checks++;
    if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL ready32 got %b want 1", bus32.in_ready); end
    bus32.In_A = a; bus32.In_B = b; bus32.ALUControl = op; bus32.in_valid = 1'b1;
    e.data = model32(a, b, op);
    e.lat  = lat_of(op, int'(b[4:0]), 32);
    q32.push_back(e);
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
  endtask

  task automatic collect32(input string name, input int hold, input bit disturb);
    exp_t e;
    int cyc = 0;
    logic [31:0] held;
    e = q32.pop_front();
    do begin
      @(posedge clk); #1; cyc++;
      if (disturb && cyc == 3) begin
        bus32.In_A = 32'hDEAD_BEEF; bus32.In_B = 32'h1234_5678; bus32.ALUControl = ALU_ADD;
      end
    end while (bus32.out_valid !== 1'b1 && cyc < 200);
    checks++;
    if (cyc != e.lat) begin errors++; $display("FAIL %s latency got %0d want %0d", name, cyc, e.lat); end
    checks++;
    if (bus32.Out_ALU !== e.data) begin errors++; $display("FAIL %s result got %h want %h", name, bus32.Out_ALU, e.data); end
    checks++;
    if (bus32.Zero !== (e.data == 32'h0)) begin errors++; $display("FAIL %s zero got %b want %b", name, bus32.Zero, e.data == 32'h0); end
    held = bus32.Out_ALU;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus32.out_valid !== 1'b1 || bus32.Out_ALU !== held || bus32.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold%0d got v=%b r=%b d=%h want v=1 r=0 d=%h", name, i, bus32.out_valid, bus32.in_ready, bus32.Out_ALU, held);
      end
    end
    bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    bus32.out_ready = 1'b0;
    checks++;
    if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1) begin
      errors++; $display("FAIL %s release got v=%b r=%b want v=0 r=1", name, bus32.out_valid, bus32.in_ready);
    end
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    exp_t e;
    int w = 0;
    @(negedge clk);
    while (bus8.in_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    checks++;
    if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL ready8 got %b want 1", bus8.in_ready); end
    bus8.In_A = a; bus8.In_B = b; bus8.ALUControl = op; bus8.in_valid = 1'b1;
    e.data = {24'h0, model8(a, b, op)};
    e.lat  = lat_of(op, int'(b[2:0]), 8);
    q8.push_back(e);
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
  endtask

  task automatic collect8(input string name);
    exp_t e;
    int cyc = 0;
    e = q8.pop_front();
    do begin @(posedge clk); #1; cyc++; end while (bus8.out_valid !== 1'b1 && cyc < 200);
    checks++;
    if (cyc != e.lat || bus8.Out_ALU !== e.data[7:0] || bus8.Zero !== (e.data == 32'h0)) begin
      errors++;
      $display("FAIL %s got lat=%0d d=%h z=%b want lat=%0d d=%h z=%b", name, cyc, bus8.Out_ALU, bus8.Zero, e.lat, e.data[7:0], e.data == 32'h0);
    end
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1 || bus32.Out_ALU !== 32'h0 || bus32.Zero !== 1'b1) begin
      errors++; $display("FAIL reset32 got v=%b r=%b d=%h z=%b want v=0 r=1 d=0 z=1", bus32.out_valid, bus32.in_ready, bus32.Out_ALU, bus32.Zero);
    end
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1 || bus8.Out_ALU !== 8'h0 || bus8.Zero !== 1'b1) begin
      errors++; $display("FAIL reset8 got v=%b r=%b d=%h z=%b want v=0 r=1 d=0 z=1", bus8.out_valid, bus8.in_ready, bus8.Out_ALU, bus8.Zero);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    drive32(32'h7FFF_FFFF, 32'h0000_0001, ALU_ADD); collect32("add_wrap", 0, 1'b0);
    drive32(32'h0000_0005, 32'h0000_0005, ALU_SUB); collect32("sub_zero", 0, 1'b0);
    drive32(32'h0000_0000, 32'h0000_0001, ALU_SUB); collect32("sub_wrap", 0, 1'b0);
    drive32(32'hF0F0_1234, 32'h0FF0_FF00, ALU_AND); collect32("and", 0, 1'b0);
    drive32(32'hF0F0_1234, 32'h0FF0_FF00, ALU_XOR); collect32("xor", 0, 1'b0);
    drive32(32'hF0F0_1234, 32'h0FF0_FF00, ALU_OR);  collect32("or", 0, 1'b0);
    drive32(32'h1234_5678, 32'h9ABC_DEF0, 4'b1111); collect32("illegal", 0, 1'b0);
  endtask

  task automatic test_shift();
    drive32(32'h8000_0000, 32'h0000_0004, ALU_SRA); collect32("sra4", 0, 1'b0);
    drive32(32'hA5A5_0001, 32'h0000_0000, ALU_SLL); collect32("sll0", 0, 1'b0);
    drive32(32'h0000_00F0, 32'h0000_001F, ALU_SRL); collect32("srl31", 0, 1'b0);
    drive32(32'h0000_00F3, 32'hFFFF_FF25, ALU_SLL); collect32("sll5_hibits", 0, 1'b0);
    drive32(32'h4000_0000, 32'h0000_0003, ALU_SRA); collect32("sra_pos", 0, 1'b0);
  endtask

  task automatic test_mul();
    drive32(32'h0001_0003, 32'h0002_0005, ALU_MUL); collect32("mul_small", 0, 1'b0);
    drive32(32'hFFFF_FFFF, 32'hFFFF_FFFF, ALU_MUL); collect32("mul_max", 0, 1'b0);
    drive32(32'h1234_5678, 32'h0000_0000, ALU_MUL); collect32("mul_zero", 0, 1'b0);
  endtask

  task automatic test_backpressure();
    drive32(32'h0000_0011, 32'h0000_0022, ALU_ADD); collect32("backpressure", 10, 1'b0);
    drive32(32'h0000_0007, 32'h0000_0009, ALU_MUL); collect32("mul_input_change", 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    exp_t dropped;
    int seen = 0;
    drive32(32'h0000_1234, 32'h0000_5678, ALU_MUL);
    repeat (10) @(posedge clk);
    #1; rst_n = 1'b0;
    dropped = q32.pop_front();
    #1;
    checks++;
    if (bus32.out_valid !== 1'b0 || bus32.Out_ALU !== 32'h0 || bus32.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid got v=%b d=%h r=%b want v=0 d=0 r=1", bus32.out_valid, bus32.Out_ALU, bus32.in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus32.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL aborted_result got %0d valid cycles want 0 (dropped %h)", seen, dropped.data); end
    drive32(32'h0000_0002, 32'h0000_0003, ALU_ADD); collect32("add_after_reset", 0, 1'b0);
  endtask

  task automatic test_random32();
    for (int i = 0; i < 24; i++) begin
      drive32($urandom, $urandom, 4'($urandom_range(0, 15)));
      collect32("rand32", 0, 1'b0);
    end
  endtask

  task automatic test_random8();
    for (int i = 0; i < 40; i++) begin
      drive8(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
      collect8("rand8");
    end
    drive8(8'hFF, 8'hFF, ALU_MUL); collect8("mul8_max");
    drive8(8'h80, 8'h07, ALU_SRA); collect8("sra8_7");
  endtask

  initial begin
    bus32.In_A = 32'h0; bus32.In_B = 32'h0; bus32.ALUControl = 4'b0000;
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b0;
    bus8.In_A = 8'h0; bus8.In_B = 8'h0; bus8.ALUControl = 4'b0000;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
    test_reset();
    test_single();
    test_shift();
    test_mul();
    test_backpressure();
    test_reset_mid();
    test_random32();
    test_random8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
